// File: rtl/lsu.sv
// Load/store unit sitting between EXU and WBU.
// Accepts one instruction at a time. Memory ops run a req/gnt then rvalid
// transaction on the data port. Load data is aligned and extended, and every
// instruction retires as a single-cycle lsu_valid_o pulse carrying a
// registered LSU->WBU bus.
// Optional build macro: LSU_MISALIGN_CHK_EN. When defined, misaligned
// half/word accesses fault without touching memory.
//
// state | meaning
// IDLE  | empty, ready to accept
// REQ   | mem_req_o held with stable addr/data/strobes until mem_gnt_i
// WAIT  | request granted, waiting for mem_rvalid_i (watchdog running)
// DONE  | lsu_valid_o pulse, may accept the next instruction

`ifndef EXU_LSU_BUS_WIDTH
`define EXU_LSU_BUS_WIDTH 156
`endif
`ifndef LSU_WBU_BUS_WIDTH
`define LSU_WBU_BUS_WIDTH 119
`endif

module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          exu_valid_i,
  input  logic [`EXU_LSU_BUS_WIDTH-1:0] exu_lsu_bus_i,
  output logic                          lsu_ready_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [31:0]                   mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  output logic [3:0]                    mem_wstrb_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [31:0]                   mem_rdata_i,
  input  logic                          mem_err_i,
  output logic                          lsu_valid_o,
  output logic [`LSU_WBU_BUS_WIDTH-1:0] lsu_wbu_bus_o
);

  // The watchdog is a down-counter loaded on entry to WAIT; terminal count
  // zero on the last allowed WAIT cycle aborts the access.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [`EXU_LSU_BUS_WIDTH-1:0]  bus_q;
  logic [`EXU_LSU_BUS_WIDTH-1:0]  src_bus;
  logic [CNT_W-1:0]               cnt_q;
  logic [`LSU_WBU_BUS_WIDTH-1:0]  wbu_q;
  logic                           accept;
  logic                           wait_timeout;
  logic                           misalign;

  logic        mem_en, mem_we, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata, alu_result, pc, jmp_target;
  logic        csr_we, gr_we, jmp_flag, break_signal, excp_flush, xret_flush;
  logic [4:0]  rd;
  logic [11:0] csr_addr;

  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        res_err;
  logic [31:0] res_final;

  assign accept = exu_valid_i & lsu_ready_o;

  // While accepting, decode straight from the EXU bus so a non-memory op
  // can retire the very next cycle; otherwise use the latched copy.
  assign src_bus = accept ? exu_lsu_bus_i : bus_q;

  assign {mem_en, mem_we, mem_size, mem_unsigned, mem_wdata, alu_result,
          csr_we, gr_we, rd, csr_addr, pc, jmp_flag, jmp_target,
          break_signal, excp_flush, xret_flush} = src_bus;

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = ((mem_size == 2'd1) && alu_result[0]) ||
                    (mem_size[1] && (alu_result[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign wait_timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == '0);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = (mem_en && !misalign) ? S_REQ : S_DONE;
        else        state_d = S_IDLE;
      end
      S_REQ:  if (mem_gnt_i) state_d = S_WAIT;
      S_WAIT: if (mem_rvalid_i || wait_timeout) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; memory signals are only driven while requesting.
  always_comb begin
    lsu_ready_o = 1'b0;
    lsu_valid_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    case (state_q)
      S_IDLE: lsu_ready_o = 1'b1;
      S_DONE: begin
        lsu_ready_o = 1'b1;
        lsu_valid_o = 1'b1;
      end
      S_REQ: begin
        mem_req_o  = 1'b1;
        mem_we_o   = mem_we;
        mem_addr_o = {alu_result[31:2], 2'b00};
        if (mem_we) begin
          case (mem_size)
            2'd0: begin
              mem_wstrb_o = 4'b0001 << alu_result[1:0];
              mem_wdata_o = {4{mem_wdata[7:0]}};
            end
            2'd1: begin
              mem_wstrb_o = alu_result[1] ? 4'b1100 : 4'b0011;
              mem_wdata_o = {2{mem_wdata[15:0]}};
            end
            default: begin
              mem_wstrb_o = 4'hF;
              mem_wdata_o = mem_wdata;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    ld_byte = mem_rdata_i[7:0];
    case (alu_result[1:0])
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      2'd3:    ld_byte = mem_rdata_i[31:24];
      default: ld_byte = mem_rdata_i[7:0];
    endcase
    ld_half = alu_result[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (mem_size)
      2'd0:    ld_data = mem_unsigned ? {24'h0, ld_byte}
                                      : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = mem_unsigned ? {16'h0, ld_half}
                                      : {{16{ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Result selection; in WAIT a transition to DONE without rvalid is a timeout.
  always_comb begin
    if (state_q == S_WAIT) res_err = mem_rvalid_i ? mem_err_i : 1'b1;
    else                   res_err = mem_en & misalign;
    if ((state_q == S_WAIT) && !res_err && !mem_we) res_final = ld_data;
    else                                             res_final = alu_result;
  end

  // Latch the EXU bus on acceptance.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    bus_q <= '0;
    else if (accept) bus_q <= exu_lsu_bus_i;
  end

  // Watchdog down-counter: reload on grant, count down through WAIT.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                 cnt_q <= '0;
    else if (state_q == S_REQ && mem_gnt_i)       cnt_q <= CNT_LOAD;
    else if (state_q == S_WAIT && cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  // Register the WBU bus whenever DONE is entered; it holds otherwise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wbu_q <= '0;
    else if (state_d == S_DONE)
      wbu_q <= {csr_we & ~res_err, res_final, gr_we & ~res_err, rd, csr_addr,
                pc, jmp_flag, jmp_target, break_signal, excp_flush | res_err,
                xret_flush};
  end

  assign lsu_wbu_bus_o = wbu_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu (built with TIMEOUT_CYCLES=4).
`ifndef EXU_LSU_BUS_WIDTH
`define EXU_LSU_BUS_WIDTH 156
`endif
`ifndef LSU_WBU_BUS_WIDTH
`define LSU_WBU_BUS_WIDTH 119
`endif

module tb_lsu;
  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         exu_valid_i = 1'b0;
  logic [155:0] exu_lsu_bus_i = '0;
  logic         lsu_ready_o, mem_req_o, mem_we_o;
  logic [31:0]  mem_addr_o, mem_wdata_o;
  logic [3:0]   mem_wstrb_o;
  logic         mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
  logic [31:0]  mem_rdata_i = '0;
  logic         lsu_valid_o;
  logic [118:0] lsu_wbu_bus_o;

  int tests = 0;
  int fails = 0;

  localparam logic [11:0] CSR_A = 12'h2A5;
  localparam logic [31:0] PC    = 32'h1000_0040;
  localparam logic [31:0] JT    = 32'h2000_0000;

  always #5 clk_i = ~clk_i;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .exu_valid_i(exu_valid_i),
    .exu_lsu_bus_i(exu_lsu_bus_i), .lsu_ready_o(lsu_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .lsu_valid_o(lsu_valid_o), .lsu_wbu_bus_o(lsu_wbu_bus_o)
  );

  function automatic logic [155:0] mk_exu(input logic mem_en, input logic we,
      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
      input logic [31:0] alu, input logic csr_we, input logic gr_we,
      input logic [4:0] rd);
    return {mem_en, we, size, uns, wdata, alu, csr_we, gr_we, rd, CSR_A, PC,
            1'b1, JT, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic logic [118:0] mk_wbu(input logic csr_we,
      input logic [31:0] fin, input logic gr_we, input logic [4:0] rd,
      input logic excp);
    return {csr_we, fin, gr_we, rd, CSR_A, PC, 1'b1, JT, 1'b0, excp, 1'b0};
  endfunction

  task automatic nclk();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    nclk();
    tests++; if (lsu_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", lsu_ready_o); end
    tests++; if (mem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b exp 0", mem_req_o); end
    tests++; if (lsu_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", lsu_valid_o); end
    tests++; if (lsu_wbu_bus_o !== '0) begin fails++; $display("FAIL reset_bus: got %h exp 0", lsu_wbu_bus_o); end
    tests++; if ({mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_we_o} !== '0) begin fails++; $display("FAIL reset_mem: got %h %h %h %b exp 0", mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_we_o); end
    rst_n_i = 1'b1;
  endtask

  task automatic test_alu();
    logic [118:0] exp;
    exp = mk_wbu(1'b1, 32'h1234, 1'b1, 5'd5, 1'b0);
    exu_valid_i = 1'b1;
    exu_lsu_bus_i = mk_exu(1'b0, 1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b1, 5'd5);
    nclk();
    tests++; if (lsu_valid_o !== 1'b1) begin fails++; $display("FAIL alu_valid: got %b exp 1", lsu_valid_o); end
    tests++; if (lsu_wbu_bus_o !== exp) begin fails++; $display("FAIL alu_bus: got %h exp %h", lsu_wbu_bus_o, exp); end
    tests++; if (mem_req_o !== 1'b0) begin fails++; $display("FAIL alu_req: got %b exp 0", mem_req_o); end
    exu_valid_i = 1'b0;
    nclk();
    tests++; if (lsu_valid_o !== 1'b0) begin fails++; $display("FAIL alu_pulse_end: got %b exp 0", lsu_valid_o); end
    tests++; if (lsu_wbu_bus_o !== exp) begin fails++; $display("FAIL alu_bus_hold: got %h exp %h", lsu_wbu_bus_o, exp); end
    tests++; if (mem_req_o !== 1'b0) begin fails++; $display("FAIL alu_req_idle: got %b exp 0", mem_req_o); end
  endtask

  task automatic test_load(input string name, input logic [31:0] alu,
      input logic [1:0] size, input logic uns, input logic [31:0] rdata,
      input logic [31:0] exp_final);
    logic [118:0] exp;
    exp = mk_wbu(1'b0, exp_final, 1'b1, 5'd7, 1'b0);
    exu_valid_i = 1'b1;
    exu_lsu_bus_i = mk_exu(1'b1, 1'b0, size, uns, 32'h0, alu, 1'b0, 1'b1, 5'd7);
    nclk();
    tests++; if ({mem_req_o, mem_we_o, mem_wstrb_o} !== 6'b10_0000) begin fails++; $display("FAIL %s_req: got req=%b we=%b strb=%b exp 1 0 0000", name, mem_req_o, mem_we_o, mem_wstrb_o); end
    tests++; if (mem_addr_o !== {alu[31:2], 2'b00}) begin fails++; $display("FAIL %s_addr: got %h exp %h", name, mem_addr_o, {alu[31:2], 2'b00}); end
    exu_valid_i = 1'b0;
    mem_gnt_i = 1'b1;
    nclk();
    mem_gnt_i = 1'b0;
    tests++; if ({mem_req_o, lsu_valid_o} !== 2'b00) begin fails++; $display("FAIL %s_wait: got req=%b valid=%b exp 0 0", name, mem_req_o, lsu_valid_o); end
    nclk();
    mem_rvalid_i = 1'b1;
    mem_rdata_i = rdata;
    nclk();
    mem_rvalid_i = 1'b0;
    tests++; if (lsu_valid_o !== 1'b1) begin fails++; $display("FAIL %s_valid: got %b exp 1", name, lsu_valid_o); end
    tests++; if (lsu_wbu_bus_o !== exp) begin fails++; $display("FAIL %s_bus: got %h exp %h", name, lsu_wbu_bus_o, exp); end
    nclk();
    tests++; if ({lsu_valid_o, lsu_ready_o} !== 2'b01) begin fails++; $display("FAIL %s_idle: got valid=%b ready=%b exp 0 1", name, lsu_valid_o, lsu_ready_o); end
  endtask

  task automatic test_store(input string name, input logic [31:0] alu,
      input logic [1:0] size, input logic [31:0] wdata, input logic [3:0] exp_strb,
      input logic [31:0] exp_wdata, input int hold);
    logic [118:0] exp;
    exp = mk_wbu(1'b0, alu, 1'b0, 5'd0, 1'b0);
    exu_valid_i = 1'b1;
    exu_lsu_bus_i = mk_exu(1'b1, 1'b1, size, 1'b0, wdata, alu, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < hold; i++) begin
      nclk();
      tests++; if ({mem_req_o, mem_we_o} !== 2'b11) begin fails++; $display("FAIL %s_req%0d: got req=%b we=%b exp 1 1", name, i, mem_req_o, mem_we_o); end
      tests++; if (mem_addr_o !== {alu[31:2], 2'b00}) begin fails++; $display("FAIL %s_addr%0d: got %h exp %h", name, i, mem_addr_o, {alu[31:2], 2'b00}); end
      tests++; if (mem_wstrb_o !== exp_strb) begin fails++; $display("FAIL %s_strb%0d: got %b exp %b", name, i, mem_wstrb_o, exp_strb); end
      tests++; if (mem_wdata_o !== exp_wdata) begin fails++; $display("FAIL %s_wdata%0d: got %h exp %h", name, i, mem_wdata_o, exp_wdata); end
      if (i == 0) begin
        exu_valid_i = 1'b0;
        exu_lsu_bus_i = '1;
      end
      if (i == hold - 1) mem_gnt_i = 1'b1;
    end
    nclk();
    mem_gnt_i = 1'b0;
    tests++; if (mem_req_o !== 1'b0) begin fails++; $display("FAIL %s_wait_req: got %b exp 0", name, mem_req_o); end
    mem_rvalid_i = 1'b1;
    nclk();
    mem_rvalid_i = 1'b0;
    tests++; if (lsu_valid_o !== 1'b1) begin fails++; $display("FAIL %s_valid: got %b exp 1", name, lsu_valid_o); end
    tests++; if (lsu_wbu_bus_o !== exp) begin fails++; $display("FAIL %s_bus: got %h exp %h", name, lsu_wbu_bus_o, exp); end
    nclk();
    tests++; if (lsu_valid_o !== 1'b0) begin fails++; $display("FAIL %s_pulse_end: got %b exp 1-cycle pulse", name, lsu_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  alus [3];
    logic [118:0] exp;
    alus[0] = 32'h0000_0011; alus[1] = 32'h0000_0022; alus[2] = 32'h0000_0033;
    exu_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exu_lsu_bus_i = mk_exu(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, alus[i], 1'b0, 1'b1, 5'(i + 1));
      nclk();
      exp = mk_wbu(1'b0, alus[i], 1'b1, 5'(i + 1), 1'b0);
      tests++; if (lsu_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_valid%0d: got %b exp 1", i, lsu_valid_o); end
      tests++; if (lsu_wbu_bus_o !== exp) begin fails++; $display("FAIL b2b_bus%0d: got %h exp %h", i, lsu_wbu_bus_o, exp); end
    end
    exu_lsu_bus_i = mk_exu(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h8000_0010, 1'b1, 1'b1, 5'd9);
    nclk();
    exu_valid_i = 1'b0;
    tests++; if ({lsu_valid_o, mem_req_o} !== 2'b01) begin fails++; $display("FAIL b2b_lw_req: got valid=%b req=%b exp 0 1", lsu_valid_o, mem_req_o); end
    mem_gnt_i = 1'b1;
    nclk();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_err_i = 1'b1;
    mem_rdata_i = 32'h5555_5555;
    nclk();
    mem_rvalid_i = 1'b0;
    mem_err_i = 1'b0;
    exp = mk_wbu(1'b0, 32'h8000_0010, 1'b0, 5'd9, 1'b1);
    tests++; if (lsu_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_err_valid: got %b exp 1", lsu_valid_o); end
    tests++; if (lsu_wbu_bus_o !== exp) begin fails++; $display("FAIL b2b_err_bus: got %h exp %h", lsu_wbu_bus_o, exp); end
    nclk();
  endtask

  task automatic test_timeout();
    logic [118:0] exp;
    exp = mk_wbu(1'b0, 32'h8000_0020, 1'b0, 5'd3, 1'b1);
    exu_valid_i = 1'b1;
    exu_lsu_bus_i = mk_exu(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h8000_0020, 1'b1, 1'b1, 5'd3);
    nclk();
    exu_valid_i = 1'b0;
    mem_gnt_i = 1'b1;
    nclk();
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if ({lsu_valid_o, lsu_ready_o, mem_req_o} !== 3'b000) begin fails++; $display("FAIL to_wait%0d: got valid=%b ready=%b req=%b exp 0 0 0", i, lsu_valid_o, lsu_ready_o, mem_req_o); end
      nclk();
    end
    tests++; if (lsu_valid_o !== 1'b1) begin fails++; $display("FAIL to_valid: got %b exp 1", lsu_valid_o); end
    tests++; if (lsu_wbu_bus_o !== exp) begin fails++; $display("FAIL to_bus: got %h exp %h", lsu_wbu_bus_o, exp); end
    nclk();
  endtask

  task automatic test_reset_mid();
    exu_valid_i = 1'b1;
    exu_lsu_bus_i = mk_exu(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h8000_0030, 1'b0, 1'b1, 5'd4);
    nclk();
    exu_valid_i = 1'b0;
    mem_gnt_i = 1'b1;
    nclk();
    mem_gnt_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    tests++; if ({mem_req_o, lsu_ready_o, lsu_valid_o} !== 3'b010) begin fails++; $display("FAIL rstmid_state: got req=%b ready=%b valid=%b exp 0 1 0", mem_req_o, lsu_ready_o, lsu_valid_o); end
    tests++; if (lsu_wbu_bus_o !== '0) begin fails++; $display("FAIL rstmid_bus: got %h exp 0", lsu_wbu_bus_o); end
    nclk();
    rst_n_i = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h1111_2222;
    nclk();
    mem_rvalid_i = 1'b0;
    tests++; if ({lsu_valid_o, lsu_ready_o} !== 2'b01) begin fails++; $display("FAIL rstmid_stray: got valid=%b ready=%b exp 0 1", lsu_valid_o, lsu_ready_o); end
    nclk();
    tests++; if (lsu_valid_o !== 1'b0) begin fails++; $display("FAIL rstmid_stray2: got %b exp 0", lsu_valid_o); end
  endtask

  task automatic test_misalign();
    logic [118:0] exp;
    exu_valid_i = 1'b1;
    exu_lsu_bus_i = mk_exu(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h8000_0002, 1'b1, 1'b1, 5'd6);
    nclk();
    exu_valid_i = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
    exp = mk_wbu(1'b0, 32'h8000_0002, 1'b0, 5'd6, 1'b1);
    tests++; if ({mem_req_o, lsu_valid_o} !== 2'b01) begin fails++; $display("FAIL mis_state: got req=%b valid=%b exp 0 1", mem_req_o, lsu_valid_o); end
    tests++; if (lsu_wbu_bus_o !== exp) begin fails++; $display("FAIL mis_bus: got %h exp %h", lsu_wbu_bus_o, exp); end
    nclk();
    tests++; if ({mem_req_o, lsu_valid_o} !== 2'b00) begin fails++; $display("FAIL mis_after: got req=%b valid=%b exp 0 0", mem_req_o, lsu_valid_o); end
`else
    exp = mk_wbu(1'b1, 32'hDEAD_BEEF, 1'b1, 5'd6, 1'b0);
    tests++; if ({mem_req_o, lsu_valid_o} !== 2'b10) begin fails++; $display("FAIL mis_state: got req=%b valid=%b exp 1 0", mem_req_o, lsu_valid_o); end
    tests++; if (mem_addr_o !== 32'h8000_0000) begin fails++; $display("FAIL mis_addr: got %h exp 80000000", mem_addr_o); end
    mem_gnt_i = 1'b1;
    nclk();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    nclk();
    mem_rvalid_i = 1'b0;
    tests++; if (lsu_valid_o !== 1'b1) begin fails++; $display("FAIL mis_valid: got %b exp 1", lsu_valid_o); end
    tests++; if (lsu_wbu_bus_o !== exp) begin fails++; $display("FAIL mis_bus: got %h exp %h", lsu_wbu_bus_o, exp); end
    nclk();
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load("lb",  32'h8000_0003, 2'd0, 1'b0, 32'h80FF_FFFF, 32'hFFFF_FF80);
    test_load("lbu", 32'h8000_0003, 2'd0, 1'b1, 32'h80FF_FFFF, 32'h0000_0080);
    test_load("lb1", 32'h8000_0001, 2'd0, 1'b0, 32'h0000_7F00, 32'h0000_007F);
    test_load("lh",  32'h8000_0002, 2'd1, 1'b0, 32'h8001_1234, 32'hFFFF_8001);
    test_load("lhu", 32'h8000_0000, 2'd1, 1'b1, 32'h8001_1234, 32'h0000_1234);
    test_load("lw",  32'h8000_0004, 2'd2, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    test_load("ls3", 32'h8000_000C, 2'd3, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D);
    test_store("sh", 32'h8000_0002, 2'd1, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 3);
    test_store("sb", 32'h8000_0001, 2'd0, 32'hFFFF_FF5A, 4'b0010, 32'h5A5A_5A5A, 1);
    test_store("sw", 32'h8000_0008, 2'd2, 32'h1122_3344, 4'b1111, 32'h1122_3344, 2);
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
